// File: rtl/mem_access_unit_pkg.sv
// Shared project header for the data-memory access unit.
// Holds the data RAM size, the default word-address width derived from it,
// the CPU access-size encodings, the access FSM state encodings and the
// alignment rule shared by the FSM.
package mem_access_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int RAM_SIZE = 4096;                   // data RAM size in bytes
  localparam int ADDR_W_DEF = $clog2(RAM_SIZE) - 2; // word-address width (10)

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    DONE   = 2'b11
  } state_e;

  // An access is rejected when its size is reserved or its byte offset is not
  // a multiple of the access size.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane: combinational lane handling for sub-word accesses.
//   size  - access size encoding (byte / half / word)
//   off   - byte offset inside the 32-bit word (addr[1:0])
//   sext  - sign-extend (1) or zero-extend (0) the extracted lane
//   word  - memory word read at the access address
//   wdata - right-aligned store data
//   ext    - loaded lane, right-aligned and extended
//   merged - memory word with only the addressed lane replaced by wdata
module byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              sext,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W-1:0]        shifted;
  logic signed [7:0]        lane_b;
  logic signed [15:0]       lane_h;
  logic signed [DATA_W-1:0] lane_b_sx;
  logic signed [DATA_W-1:0] lane_h_sx;

  always_comb begin
    shifted   = word >> {off, 3'b000};
    lane_b    = shifted[7:0];
    lane_h    = shifted[15:0];
    // Signed-to-signed widening assignment replicates the lane's top bit.
    lane_b_sx = lane_b;
    lane_h_sx = lane_h;
    case (size)
      SZ_BYTE: ext = sext ? lane_b_sx : {24'd0, shifted[7:0]};
      SZ_HALF: ext = sext ? lane_h_sx : {16'd0, shifted[15:0]};
      default: ext = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{off, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between a CPU and a
// word-wide data memory with combinational read and posedge write.
//   clk, rst        - clock, synchronous active-high reset
//   req, wr, size,  - CPU request (accepted when ready=1), store select,
//   sext, addr,       access size, load sign-extend, byte address,
//   wdata             right-aligned store data
//   ready           - idle, a request is accepted this cycle
//   done, err       - one-cycle completion pulse, error flag valid with done
//   rdata           - load result, held until the next completed load
//   m_addr, m_din,  - memory word address, write data, write enable
//   m_we, m_dout      and combinational read data
// Sub-word stores are read-modify-write: the word is read in ACCESS, merged,
// and written back in WRITE.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_din,
  output logic              m_we,
  input  logic [31:0]       m_dout
);

  state_e state_q, state_d;

  logic              wr_p0;
  logic [1:0]        size_p0;
  logic              sext_p0;
  logic [ADDR_W+1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       merged_p1;
  logic [31:0]       rdata_q;

  logic              bad;
  logic              load_en;
  logic              merge_en;
  logic [31:0]       lane_ext;
  logic [31:0]       lane_merged;

  logic              unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign bad    = access_bad(size_p0, addr_p0[1:0]);
  assign m_addr = addr_p0[ADDR_W+1:2];
  assign rdata  = rdata_q;

  byte_lane u_lane (
    .size   (size_p0),
    .off    (addr_p0[1:0]),
    .sext   (sext_p0),
    .word   (m_dout),
    .wdata  (wdata_p0),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // m_we is gated by rst so a write cycle that coincides with reset is dropped.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    m_we     = 1'b0;
    m_din    = merged_p1;
    load_en  = 1'b0;
    merge_en = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = DONE;
        if (!bad) begin
          if (!wr_p0) begin
            load_en = 1'b1;
          end else if (size_p0 == SZ_WORD) begin
            m_we  = !rst;
            m_din = wdata_p0;
          end else begin
            merge_en = 1'b1;
            state_d  = WRITE;
          end
        end
      end
      WRITE: begin
        m_we    = !rst;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err     = bad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: request capture at accept
  always_ff @(posedge clk) begin
    if (ready && req) begin
      wr_p0    <= wr;
      size_p0  <= size;
      sext_p0  <= sext;
      addr_p0  <= addr[ADDR_W+1:0];
      wdata_p0 <= wdata;
    end
  end

  // Stage p1: merged word for the read-modify-write path
  always_ff @(posedge clk) begin
    if (merge_en) merged_p1 <= lane_merged;
  end

  always_ff @(posedge clk) begin
    if (rst)          rdata_q <= '0;
    else if (load_en) rdata_q <= lane_ext;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  m_addr;
  logic [31:0] m_din;
  logic        m_we;
  logic [31:0] m_dout;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, posedge write; preload port for the bench.
  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;
  assign m_dout = mem[m_addr];
  always @(posedge clk) begin
    if (pl_en)     mem[pl_idx] <= pl_data;
    else if (m_we) mem[m_addr] <= m_din;
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          n_cmp, n_bad;
  int          cyc, remaining, done_cnt, acc_cnt, mwe_total, wr_seen;
  int          acc_cyc, last_lat;
  logic        last_err, started, rst_pending;
  logic [31:0] exp_rdata;
  logic        p_err, p_wr;
  logic [9:0]  p_widx;
  logic [31:0] p_rdata, p_new;
  int          p_writes;
  int          done_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%08h required=%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Predict the outcome of an access from its inputs and the reference memory.
  task automatic model_accept();
    logic [1:0]  off;
    logic [31:0] w, v, nw;
    int          nb;
    off    = addr[1:0];
    p_widx = addr[11:2];
    p_wr   = wr;
    p_err  = (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
    w      = ref_mem[p_widx];
    nb     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    v      = w >> (8 * off);
    if (nb == 1) begin
      v = v & 32'hFF;
      if (sext && v[7]) v = v | 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (sext && v[15]) v = v | 32'hFFFF0000;
    end
    nw = w;
    if (!p_err) begin
      for (int i = 0; i < nb; i++) begin
        nw = (nw & ~(32'hFF << (8 * (off + i)))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * (off + i)));
      end
    end
    p_rdata   = (!p_err && !wr) ? v : exp_rdata;
    p_new     = (!p_err && wr) ? nw : w;
    p_writes  = (!p_err && wr) ? 1 : 0;
    remaining = p_err ? 2 : (wr && size != 2'b10) ? 3 : 2;
    acc_cyc   = cyc;
    wr_seen   = 0;
    acc_cnt++;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (pl_en) ref_mem[pl_idx] = pl_data;
      if (rst_pending) begin
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_m_we", m_we, 0);
        check("rst_rdata", rdata, 0);
        rst_pending = 1'b0;
      end
      if (started) begin
        check("ready", ready, remaining == 0);
        check("done", done, remaining == 1);
        if (remaining == 0) check("m_we_idle", m_we, 0);
        if (remaining >= 2) check("m_addr", m_addr, p_widx);
        if (m_we) begin
          wr_seen++;
          mwe_total++;
        end
        if (remaining == 1) begin
          check("err", err, p_err);
          check("rdata", rdata, p_rdata);
          check("m_we_count", wr_seen, p_writes);
          ref_mem[p_widx] = p_new;
          check("mem_word", mem[p_widx], ref_mem[p_widx]);
          exp_rdata = p_rdata;
          last_lat  = cyc - acc_cyc;
          last_err  = err;
          done_cnt++;
          done_q.push_back(cyc);
        end else begin
          check("rdata_hold", rdata, exp_rdata);
        end
      end
      if (rst) begin
        remaining   = 0;
        exp_rdata   = '0;
        started     = 1'b1;
        rst_pending = 1'b1;
      end else if (started) begin
        if (remaining > 0) remaining--;
        else if (req) model_accept();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx[9:0]; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    for (int k = 0; k < 20 && done_cnt < tgt; k++) step();
    check("done_reached", done_cnt >= tgt, 1);
  endtask

  task automatic xact(input logic w, input logic [1:0] s, input logic x,
                      input logic [31:0] a, input logic [31:0] d);
    int tgt;
    tgt = done_cnt + 1;
    wr = w; size = s; sext = x; addr = a; wdata = d; req = 1'b1;
    step();
    req = 1'b0;
    wait_done(tgt);
  endtask

  initial begin
    int wt, dc, ac, nq;
    n_cmp = 0; n_bad = 0; cyc = 0; remaining = 0; done_cnt = 0; acc_cnt = 0;
    mwe_total = 0; wr_seen = 0; acc_cyc = 0; last_lat = 0; last_err = 0;
    started = 0; rst_pending = 0; exp_rdata = '0;
    p_err = 0; p_wr = 0; p_widx = '0; p_rdata = '0; p_new = '0; p_writes = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    fork
      monitor();
    join_none
    step(); step();
    rst = 1'b0;
    preload(0, 32'h0); preload(1, 32'h0); preload(4, 32'h0); preload(8, 32'h0);
    step();

    // Word store then word load
    xact(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
    check("lit_sw_lat", last_lat, 2);
    xact(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    check("lit_lw_rdata", rdata, 32'hDEADBEEF);
    check("lit_lw_err", last_err, 0);
    check("lit_lw_lat", last_lat, 2);

    // Byte store read-modify-write
    preload(4, 32'h11223344);
    wt = mwe_total;
    xact(1'b1, 2'b00, 1'b0, 32'h013, 32'h0000005A);
    check("lit_sb_mem", mem[4], 32'h5A223344);
    check("lit_sb_lat", last_lat, 3);
    check("lit_sb_writes", mwe_total - wt, 1);

    // Sub-word loads
    preload(0, 32'h80FF7F01);
    xact(1'b0, 2'b00, 1'b1, 32'h002, 32'h0);
    check("lit_lb", rdata, 32'hFFFFFFFF);
    xact(1'b0, 2'b00, 1'b0, 32'h003, 32'h0);
    check("lit_lbu", rdata, 32'h00000080);
    xact(1'b0, 2'b01, 1'b1, 32'h002, 32'h0);
    check("lit_lh", rdata, 32'hFFFF80FF);
    xact(1'b0, 2'b01, 1'b1, 32'h000, 32'h0);
    check("lit_lh_pos", rdata, 32'h00007F01);

    // Misaligned halfword store
    wt = mwe_total;
    xact(1'b1, 2'b01, 1'b0, 32'h001, 32'h0000BEEF);
    check("lit_sh_mis_err", last_err, 1);
    check("lit_sh_mis_writes", mwe_total - wt, 0);
    check("lit_sh_mis_mem", mem[0], 32'h80FF7F01);
    check("lit_sh_mis_rdata", rdata, 32'h00007F01);

    // Halfword store / load, reserved size, misaligned word
    preload(1, 32'hAAAABBBB);
    xact(1'b1, 2'b01, 1'b0, 32'h006, 32'hFFFF1234);
    check("lit_sh_mem", mem[1], 32'h1234BBBB);
    xact(1'b0, 2'b01, 1'b0, 32'h006, 32'h0);
    check("lit_lhu", rdata, 32'h00001234);
    xact(1'b0, 2'b11, 1'b0, 32'h000, 32'h0);
    check("lit_rsvd_err", last_err, 1);
    xact(1'b0, 2'b10, 1'b0, 32'h012, 32'h0);
    check("lit_lw_mis_err", last_err, 1);
    check("lit_lw_mis_rdata", rdata, 32'h00001234);

    // Reset during the WRITE cycle of a byte store
    preload(8, 32'hCAFEF00D);
    wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h021; wdata = 32'h77; req = 1'b1;
    step();
    req = 1'b0;
    step();
    rst = 1'b1;
    dc = done_cnt; wt = mwe_total;
    step();
    rst = 1'b0;
    check("lit_rst_ready", ready, 1);
    repeat (4) step();
    check("lit_rst_nodone", done_cnt, dc);
    check("lit_rst_writes", mwe_total - wt, 0);
    check("lit_rst_mem", mem[8], 32'hCAFEF00D);

    // Back-to-back loads with req held high
    dc = done_cnt; ac = acc_cnt;
    wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h010; wdata = '0; req = 1'b1;
    for (int k = 0; k < 30 && done_cnt < dc + 3; k++) step();
    req = 1'b0;
    check("lit_b2b_dones", done_cnt - dc, 3);
    check("lit_b2b_accepts", acc_cnt - ac, 3);
    nq = done_q.size();
    if (nq >= 3) begin
      check("lit_b2b_gap1", done_q[nq-1] - done_q[nq-2], 3);
      check("lit_b2b_gap2", done_q[nq-2] - done_q[nq-3], 3);
    end else begin
      check("lit_b2b_qsize", nq, 3);
    end
    check("lit_b2b_rdata", rdata, 32'h5A223344);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
